// File: rtl/rs_generic_station_if.sv
// Issue-side valid/ready bundle between the reservation station and its FU.
// The station drives the master side; the FU drives ready on the slave side.
interface rs_generic_station_if #(
  parameter int XLEN      = 64,
  parameter int PRD_W     = 6,
  parameter int ROBID_W   = 4,
  parameter int PAYLOAD_W = 96
);
  logic                 valid;
  logic                 ready;
  logic [ROBID_W-1:0]   robid;
  logic [PRD_W-1:0]     prd;
  logic [XLEN-1:0]      data1;
  logic [XLEN-1:0]      data2;
  logic [PAYLOAD_W-1:0] payload;

  modport master (
    output valid, robid, prd,
    output data1, data2, payload,
    input  ready
  );

  modport slave (
    input  valid, robid, prd,
    input  data1, data2, payload,
    output ready
  );
endinterface

// File: rtl/rs_generic_station.sv
// Unified reservation station: DISP_W dispatch lanes, WB_PORTS wakeup, one issue.
// RS_AGE_ORDER_EN selects oldest-first issue; otherwise lowest-index first.
module rs_generic_station #(
  parameter int DEPTH     = 8,
  parameter int DISP_W    = 2,
  parameter int WB_PORTS  = 3,
  parameter int XLEN      = 64,
  parameter int PRD_W     = 6,
  parameter int ROBID_W   = 4,
  parameter int PAYLOAD_W = 96
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DISP_W-1:0]             disp_valid_i,
  output logic [DISP_W-1:0]             disp_ready_o,
  input  logic [DISP_W*ROBID_W-1:0]     disp_robid_i,
  input  logic [DISP_W*PRD_W-1:0]       disp_prd_i,
  input  logic [DISP_W*PRD_W-1:0]       disp_prs1_i,
  input  logic [DISP_W*PRD_W-1:0]       disp_prs2_i,
  input  logic [DISP_W-1:0]             disp_rs1_rdy_i,
  input  logic [DISP_W-1:0]             disp_rs2_rdy_i,
  input  logic [DISP_W*XLEN-1:0]        disp_data1_i,
  input  logic [DISP_W*XLEN-1:0]        disp_data2_i,
  input  logic [DISP_W*PAYLOAD_W-1:0]   disp_payload_i,
  input  logic [WB_PORTS-1:0]           wb_valid_i,
  input  logic [WB_PORTS*PRD_W-1:0]     wb_prd_i,
  input  logic [WB_PORTS*XLEN-1:0]      wb_data_i,
  rs_generic_station_if.master          iss,
  input  logic                          flush_i,
  output logic [$clog2(DEPTH+1)-1:0]    count_o
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LN_W  = (DISP_W > 1) ? $clog2(DISP_W) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]     vld, rdy1, rdy2;
  logic [PRD_W-1:0]     tag1 [DEPTH];
  logic [PRD_W-1:0]     tag2 [DEPTH];
  logic [XLEN-1:0]      dat1 [DEPTH];
  logic [XLEN-1:0]      dat2 [DEPTH];
  logic [ROBID_W-1:0]   rob_q [DEPTH];
  logic [PRD_W-1:0]     prd_q [DEPTH];
  logic [PAYLOAD_W-1:0] pay_q [DEPTH];
`ifdef RS_AGE_ORDER_EN
  logic [DEPTH-1:0]     older [DEPTH];
`endif

  // Returns {hit, data}; scanning downward lets the lowest port win.
  function automatic logic [XLEN:0] snoop(
    input logic [PRD_W-1:0] tag
  );
    logic [XLEN:0] r;
    r = '0;
    for (int p = WB_PORTS-1; p >= 0; p--) begin
      if (wb_valid_i[p] &&
          wb_prd_i[p*PRD_W +: PRD_W] == tag)
        r = {1'b1, wb_data_i[p*XLEN +: XLEN]};
    end
    return r;
  endfunction

  logic [CNT_W-1:0] cnt, free_cnt;
  logic [DISP_W-1:0] acc;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEPTH; i++)
      cnt = cnt + CNT_W'(vld[i]);
  end

  assign free_cnt = CNT_W'(DEPTH) - cnt;
  assign count_o  = cnt;

  always_comb begin
    for (int k = 0; k < DISP_W; k++)
      disp_ready_o[k] = (free_cnt > CNT_W'(k)) && !flush_i;
  end

  assign acc = disp_valid_i & disp_ready_o;

  logic [IDX_W-1:0] slot [DISP_W];

  always_comb begin
    int n;
    n = 0;
    for (int k = 0; k < DISP_W; k++) slot[k] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!vld[i] && n < DISP_W) begin
        slot[n] = IDX_W'(i);
        n = n + 1;
      end
    end
  end

  logic [DEPTH-1:0] alc;
  logic [LN_W-1:0]  alc_ln [DEPTH];

  always_comb begin
    alc = '0;
    for (int i = 0; i < DEPTH; i++) alc_ln[i] = '0;
    for (int k = 0; k < DISP_W; k++) begin
      if (acc[k]) begin
        alc[slot[k]]    = 1'b1;
        alc_ln[slot[k]] = LN_W'(k);
      end
    end
  end

  logic [XLEN:0]     lb1 [DISP_W];
  logic [XLEN:0]     lb2 [DISP_W];
  logic [XLEN-1:0]   ld1 [DISP_W];
  logic [XLEN-1:0]   ld2 [DISP_W];
  logic [DISP_W-1:0] lr1, lr2;

  always_comb begin
    for (int k = 0; k < DISP_W; k++) begin
      lb1[k] = snoop(disp_prs1_i[k*PRD_W +: PRD_W]);
      lb2[k] = snoop(disp_prs2_i[k*PRD_W +: PRD_W]);
      lr1[k] = disp_rs1_rdy_i[k] | lb1[k][XLEN];
      lr2[k] = disp_rs2_rdy_i[k] | lb2[k][XLEN];
      ld1[k] = disp_rs1_rdy_i[k] ?
               disp_data1_i[k*XLEN +: XLEN] :
               lb1[k][XLEN-1:0];
      ld2[k] = disp_rs2_rdy_i[k] ?
               disp_data2_i[k*XLEN +: XLEN] :
               lb2[k][XLEN-1:0];
    end
  end

  logic [XLEN:0] wk1 [DEPTH];
  logic [XLEN:0] wk2 [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wk1[i] = snoop(tag1[i]);
      wk2[i] = snoop(tag2[i]);
    end
  end

  logic [DEPTH-1:0] elig, sel;
  logic fire;

  assign elig = vld & rdy1 & rdy2;

`ifdef RS_AGE_ORDER_EN
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      sel[i] = elig[i];
      for (int j = 0; j < DEPTH; j++)
        if (j != i && elig[j] && older[j][i])
          sel[i] = 1'b0;
    end
  end
`else
  always_comb begin
    logic found;
    found = 1'b0;
    sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (elig[i] && !found) begin
        sel[i] = 1'b1;
        found = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    iss.robid   = '0;
    iss.prd     = '0;
    iss.data1   = '0;
    iss.data2   = '0;
    iss.payload = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel[i]) begin
        iss.robid   = rob_q[i];
        iss.prd     = prd_q[i];
        iss.data1   = dat1[i];
        iss.data2   = dat2[i];
        iss.payload = pay_q[i];
      end
    end
  end

  assign iss.valid = (|elig) && !flush_i;
  assign fire      = iss.valid && iss.ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld  <= '0;
      rdy1 <= '0;
      rdy2 <= '0;
`ifdef RS_AGE_ORDER_EN
      older <= '{default: '0};
`endif
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (flush_i) begin
          vld[i] <= 1'b0;
        end else if (alc[i]) begin
          vld[i]   <= 1'b1;
          rdy1[i]  <= lr1[alc_ln[i]];
          rdy2[i]  <= lr2[alc_ln[i]];
          dat1[i]  <= ld1[alc_ln[i]];
          dat2[i]  <= ld2[alc_ln[i]];
          tag1[i]  <= disp_prs1_i[alc_ln[i]*PRD_W +: PRD_W];
          tag2[i]  <= disp_prs2_i[alc_ln[i]*PRD_W +: PRD_W];
          rob_q[i] <= disp_robid_i[alc_ln[i]*ROBID_W +: ROBID_W];
          prd_q[i] <= disp_prd_i[alc_ln[i]*PRD_W +: PRD_W];
          pay_q[i] <= disp_payload_i[alc_ln[i]*PAYLOAD_W +: PAYLOAD_W];
        end else begin
          if (fire && sel[i]) vld[i] <= 1'b0;
          if (vld[i] && !rdy1[i] && wk1[i][XLEN]) begin
            rdy1[i] <= 1'b1;
            dat1[i] <= wk1[i][XLEN-1:0];
          end
          if (vld[i] && !rdy2[i] && wk2[i][XLEN]) begin
            rdy2[i] <= 1'b1;
            dat2[i] <= wk2[i][XLEN-1:0];
          end
        end
      end
`ifdef RS_AGE_ORDER_EN
      // New entries are younger than all residents; lower lanes are older.
      if (!flush_i) begin
        for (int a = 0; a < DEPTH; a++)
          for (int b = 0; b < DEPTH; b++)
            if (alc[a])
              older[a][b] <= alc[b] && (alc_ln[b] > alc_ln[a]);
            else if (alc[b])
              older[a][b] <= 1'b1;
      end
`endif
    end
  end
endmodule

// File: tb/tb_rs_generic_station.sv
// Directed bench for rs_generic_station: vector table plus fill/age/reset
// sequences; expectations follow the RS_AGE_ORDER_EN setting.
module tb_rs_generic_station;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]   disp_valid_i, disp_ready_o;
  logic [7:0]   disp_robid_i;
  logic [11:0]  disp_prd_i, disp_prs1_i, disp_prs2_i;
  logic [1:0]   disp_rs1_rdy_i, disp_rs2_rdy_i;
  logic [127:0] disp_data1_i, disp_data2_i;
  logic [191:0] disp_payload_i;
  logic [2:0]   wb_valid_i;
  logic [17:0]  wb_prd_i;
  logic [191:0] wb_data_i;
  logic         flush_i;
  logic [3:0]   count_o;

  rs_generic_station_if bus ();

  rs_generic_station dut (
    .clk(clk), .rst(rst),
    .disp_valid_i(disp_valid_i), .disp_ready_o(disp_ready_o),
    .disp_robid_i(disp_robid_i), .disp_prd_i(disp_prd_i),
    .disp_prs1_i(disp_prs1_i), .disp_prs2_i(disp_prs2_i),
    .disp_rs1_rdy_i(disp_rs1_rdy_i), .disp_rs2_rdy_i(disp_rs2_rdy_i),
    .disp_data1_i(disp_data1_i), .disp_data2_i(disp_data2_i),
    .disp_payload_i(disp_payload_i),
    .wb_valid_i(wb_valid_i), .wb_prd_i(wb_prd_i),
    .wb_data_i(wb_data_i),
    .iss(bus), .flush_i(flush_i), .count_o(count_o)
  );

  typedef struct packed {
    logic v; logic [3:0] rob;
    logic [5:0] p1; logic r1;
    logic [5:0] p2; logic r2;
    logic [63:0] d1; logic [63:0] d2;
  } lane_t;

  typedef struct packed {
    logic [2:0] v;
    logic [5:0] t0; logic [5:0] t1; logic [5:0] t2;
    logic [63:0] d0; logic [63:0] d1; logic [63:0] d2;
  } wb_t;

  typedef struct packed {
    logic ev; logic [3:0] rob;
    logic [63:0] d1; logic [63:0] d2;
    logic [3:0] cnt; logic [1:0] rdy;
  } exp_t;

  typedef struct packed {
    lane_t a; lane_t b; wb_t w;
    logic ir; logic fl; exp_t x;
  } vec_t;

  localparam lane_t NL = '0;
  localparam wb_t   NW = '0;

  int checks = 0;
  int failures = 0;

  function automatic lane_t L(input logic [3:0] rob,
      input logic [5:0] p1, input logic r1,
      input logic [5:0] p2, input logic r2,
      input logic [63:0] d1, input logic [63:0] d2);
    return '{1'b1, rob, p1, r1, p2, r2, d1, d2};
  endfunction

  function automatic lane_t R(input logic [3:0] rob,
      input logic [63:0] d1, input logic [63:0] d2);
    return L(rob, 6'd0, 1'b1, 6'd0, 1'b1, d1, d2);
  endfunction

  function automatic wb_t W(input logic [2:0] v,
      input logic [5:0] t0, input logic [5:0] t1,
      input logic [5:0] t2, input logic [63:0] d0,
      input logic [63:0] d1, input logic [63:0] d2);
    return '{v, t0, t1, t2, d0, d1, d2};
  endfunction

  function automatic exp_t E(input logic ev,
      input logic [3:0] rob, input logic [63:0] d1,
      input logic [63:0] d2, input logic [3:0] cnt,
      input logic [1:0] rdy);
    return '{ev, rob, d1, d2, cnt, rdy};
  endfunction

  task automatic chk(input string nm,
      input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_lane(input int k, input lane_t l);
    disp_valid_i[k]          = l.v;
    disp_robid_i[k*4 +: 4]   = l.rob;
    disp_prd_i[k*6 +: 6]     = {2'b00, l.rob};
    disp_prs1_i[k*6 +: 6]    = l.p1;
    disp_prs2_i[k*6 +: 6]    = l.p2;
    disp_rs1_rdy_i[k]        = l.r1;
    disp_rs2_rdy_i[k]        = l.r2;
    disp_data1_i[k*64 +: 64] = l.d1;
    disp_data2_i[k*64 +: 64] = l.d2;
    disp_payload_i[k*96 +: 96] = {92'd0, l.rob};
  endtask

  task automatic drive(input lane_t a, input lane_t b,
      input wb_t w, input logic ir, input logic fl);
    set_lane(0, a);
    set_lane(1, b);
    wb_valid_i = w.v;
    wb_prd_i   = {w.t2, w.t1, w.t0};
    wb_data_i  = {w.d2, w.d1, w.d0};
    bus.ready  = ir;
    flush_i    = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t tv [25];
  logic [3:0] ord [9];
  logic [3:0] cexp [9];
  logic age;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
`ifdef RS_AGE_ORDER_EN
    age = 1'b1;
`else
    age = 1'b0;
`endif
    tv[0]  = '{NL, NL, NW, 1'b1, 1'b0, E(0, 0, 0, 0, 0, 3)};
    tv[1]  = '{R(3, 'h11, 'h22), NL, NW, 1'b1, 1'b0,
               E(0, 0, 0, 0, 0, 3)};
    tv[2]  = '{NL, NL, NW, 1'b1, 1'b0,
               E(1, 3, 'h11, 'h22, 1, 3)};
    tv[3]  = '{NL, NL, NW, 1'b1, 1'b0, E(0, 0, 0, 0, 0, 3)};
    tv[4]  = '{L(4, 9, 0, 0, 1, 0, 'h5), NL, NW, 1'b1, 1'b0,
               E(0, 0, 0, 0, 0, 3)};
    tv[5]  = '{NL, NL, NW, 1'b1, 1'b0, E(0, 0, 0, 0, 1, 3)};
    tv[6]  = '{NL, NL, W(3'b010, 0, 9, 0, 0, 'hABCD, 0),
               1'b1, 1'b0, E(0, 0, 0, 0, 1, 3)};
    tv[7]  = '{NL, NL, NW, 1'b1, 1'b0,
               E(1, 4, 'hABCD, 'h5, 1, 3)};
    tv[8]  = '{L(5, 9, 0, 0, 1, 0, 'h6), NL,
               W(3'b010, 0, 9, 0, 0, 'h77, 0),
               1'b1, 1'b0, E(0, 0, 0, 0, 0, 3)};
    tv[9]  = '{NL, NL, NW, 1'b1, 1'b0,
               E(1, 5, 'h77, 'h6, 1, 3)};
    tv[10] = '{L(6, 5, 0, 9, 0, 0, 0), NL, NW, 1'b0, 1'b0,
               E(0, 0, 0, 0, 0, 3)};
    tv[11] = '{NL, NL, W(3'b111, 5, 9, 5, 'h1, 'h99, 'h2),
               1'b0, 1'b0, E(0, 0, 0, 0, 1, 3)};
    tv[12] = '{NL, NL, NW, 1'b1, 1'b0,
               E(1, 6, 'h1, 'h99, 1, 3)};
    tv[13] = '{L(7, 5, 0, 0, 1, 0, 'h7), NL,
               W(3'b110, 5, 5, 5, 'hE, 'h33, 'h44),
               1'b1, 1'b0, E(0, 0, 0, 0, 0, 3)};
    tv[14] = '{NL, NL, NW, 1'b1, 1'b0,
               E(1, 7, 'h33, 'h7, 1, 3)};
    tv[15] = '{NL, NL, NW, 1'b1, 1'b0, E(0, 0, 0, 0, 0, 3)};
    tv[16] = '{R(8, 'h80, 'h81), R(9, 'h90, 'h91), NW,
               1'b1, 1'b0, E(0, 0, 0, 0, 0, 3)};
    tv[17] = '{NL, NL, NW, 1'b1, 1'b0,
               E(1, 8, 'h80, 'h81, 2, 3)};
    tv[18] = '{NL, NL, NW, 1'b1, 1'b0,
               E(1, 9, 'h90, 'h91, 1, 3)};
    tv[19] = '{NL, NL, NW, 1'b1, 1'b0, E(0, 0, 0, 0, 0, 3)};
    tv[20] = '{L(1, 40, 0, 0, 1, 0, 0), L(2, 40, 0, 0, 1, 0, 0),
               NW, 1'b0, 1'b0, E(0, 0, 0, 0, 0, 3)};
    tv[21] = '{L(3, 40, 0, 0, 1, 0, 0), L(4, 40, 0, 0, 1, 0, 0),
               NW, 1'b0, 1'b0, E(0, 0, 0, 0, 2, 3)};
    tv[22] = '{R(5, 'h55, 'h56), NL, NW, 1'b0, 1'b0,
               E(0, 0, 0, 0, 4, 3)};
    tv[23] = '{R(11, 'hB, 0), R(12, 'hC, 0), NW, 1'b1, 1'b1,
               E(0, 0, 0, 0, 5, 0)};
    tv[24] = '{NL, NL, NW, 1'b1, 1'b0, E(0, 0, 0, 0, 0, 3)};

    rst = 1'b1;
    drive(NL, NL, NW, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;

    for (int i = 0; i < 25; i++) begin
      drive(tv[i].a, tv[i].b, tv[i].w, tv[i].ir, tv[i].fl);
      @(negedge clk);
      chk($sformatf("v%0d valid", i), 64'(bus.valid), 64'(tv[i].x.ev));
      chk($sformatf("v%0d count", i), 64'(count_o), 64'(tv[i].x.cnt));
      chk($sformatf("v%0d ready", i), 64'(disp_ready_o),
          64'(tv[i].x.rdy));
      if (tv[i].x.ev) begin
        chk($sformatf("v%0d robid", i), 64'(bus.robid),
            64'(tv[i].x.rob));
        chk($sformatf("v%0d data1", i), bus.data1, tv[i].x.d1);
        chk($sformatf("v%0d data2", i), bus.data2, tv[i].x.d2);
        chk($sformatf("v%0d payload", i), 64'(bus.payload[3:0]),
            64'(tv[i].x.rob));
      end
      tick();
    end

    // fill to capacity under backpressure
    for (int p = 0; p < 4; p++) begin
      drive(R(4'(2*p), 64'(2*p), 0), R(4'(2*p+1), 64'(2*p+1), 0),
            NW, 1'b0, 1'b0);
      tick();
    end
    drive(R(14, 'hE, 0), R(15, 'hF, 0), NW, 1'b0, 1'b0);
    @(negedge clk);
    chk("full ready", 64'(disp_ready_o), 0);
    chk("full count", 64'(count_o), 8);
    chk("full valid", 64'(bus.valid), 1);
    chk("full robid", 64'(bus.robid), 0);
    tick();
    drive(NL, NL, NW, 1'b0, 1'b0);
    @(negedge clk);
    chk("hold robid", 64'(bus.robid), 0);
    chk("hold data1", bus.data1, 0);
    chk("hold count", 64'(count_o), 8);
    tick();

    cexp = '{4'd8, 4'd7, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
    if (age)
      ord = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd13};
    else
      ord = '{4'd0, 4'd1, 4'd13, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    for (int s = 0; s < 9; s++) begin
      drive(s == 1 ? R(13, 'hD, 0) : NL, NL, NW, 1'b1, 1'b0);
      @(negedge clk);
      chk($sformatf("drain%0d valid", s), 64'(bus.valid), 1);
      chk($sformatf("drain%0d robid", s), 64'(bus.robid),
          64'(ord[s]));
      chk($sformatf("drain%0d count", s), 64'(count_o),
          64'(cexp[s]));
      if (s == 1)
        chk("drain1 ready", 64'(disp_ready_o), 1);
      tick();
    end
    drive(NL, NL, NW, 1'b0, 1'b0);
    @(negedge clk);
    chk("empty valid", 64'(bus.valid), 0);
    chk("empty count", 64'(count_o), 0);

    // entry 6 waits, entry 2 is recycled younger
    drive(L(0, 20, 0, 0, 1, 0, 0), L(1, 21, 0, 0, 1, 0, 0),
          NW, 1'b0, 1'b0);
    tick();
    drive(R(2, 'h2, 0), L(3, 23, 0, 0, 1, 0, 0), NW, 1'b0, 1'b0);
    tick();
    drive(L(4, 24, 0, 0, 1, 0, 0), L(5, 25, 0, 0, 1, 0, 0),
          NW, 1'b0, 1'b0);
    tick();
    drive(L(6, 26, 0, 0, 1, 0, 0), NL, NW, 1'b0, 1'b0);
    tick();
    drive(NL, NL, NW, 1'b1, 1'b0);
    @(negedge clk);
    chk("age first robid", 64'(bus.robid), 2);
    chk("age first count", 64'(count_o), 7);
    tick();
    drive(R(10, 'hA, 0), NL, W(3'b001, 26, 0, 0, 'h66, 0, 0),
          1'b0, 1'b0);
    @(negedge clk);
    chk("age wait valid", 64'(bus.valid), 0);
    chk("age wait count", 64'(count_o), 6);
    tick();
    drive(NL, NL, NW, 1'b1, 1'b0);
    @(negedge clk);
    chk("age pick valid", 64'(bus.valid), 1);
    chk("age pick robid", 64'(bus.robid), age ? 6 : 10);
    chk("age pick data1", bus.data1, age ? 'h66 : 'hA);
    chk("age pick count", 64'(count_o), 7);
    tick();
    @(negedge clk);
    chk("age next robid", 64'(bus.robid), age ? 10 : 6);
    chk("age next data1", bus.data1, age ? 'hA : 'h66);
    tick();
    drive(NL, NL, NW, 1'b0, 1'b0);
    @(negedge clk);
    chk("age left valid", 64'(bus.valid), 0);
    chk("age left count", 64'(count_o), 5);
    tick();

    // reset beats dispatch and wakeup in the same cycle
    rst = 1'b1;
    drive(R(1, 'h1, 0), R(2, 'h2, 0),
          W(3'b001, 20, 0, 0, 'h5, 0, 0), 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    drive(NL, NL, NW, 1'b1, 1'b0);
    @(negedge clk);
    chk("rst count", 64'(count_o), 0);
    chk("rst valid", 64'(bus.valid), 0);
    chk("rst ready", 64'(disp_ready_o), 3);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
